// File: rtl/isqrt_pipe_arbiter_pkg.sv
// Shared types and constants for the round-robin front end of the shared isqrt pipe.
package isqrt_arb_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int LATENCY_DEF = 16;
    localparam int RSP_LAT     = LATENCY_DEF + 2;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/isqrt_pipe_arbiter_if.sv
// Requester, pipe and response signals of the isqrt arbiter.
// Handshake: an operand moves when req_vld[i] & req_rdy[i] at a rising clk edge; pipe and rsp have no backpressure.
interface isqrt_pipe_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 16
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(LATENCY + 3);

    logic                 en;
    logic [N_REQ-1:0]     req_vld;
    logic [N_REQ*32-1:0]  req_x;
    logic [N_REQ-1:0]     req_rdy;
    logic                 pipe_vld;
    logic [31:0]          pipe_x;
    logic                 pipe_res_vld;
    logic [15:0]          pipe_res_y;
    logic [N_REQ-1:0]     rsp_vld;
    logic [15:0]          rsp_y;
    logic [ID_W-1:0]      rsp_id;
    logic [CNT_W-1:0]     inflight;
    logic                 err;

    modport master (
        output en, req_vld, req_x, pipe_res_vld, pipe_res_y,
        input  req_rdy, pipe_vld, pipe_x, rsp_vld, rsp_y, rsp_id, inflight, err
    );

    modport slave (
        input  en, req_vld, req_x, pipe_res_vld, pipe_res_y,
        output req_rdy, pipe_vld, pipe_x, rsp_vld, rsp_y, rsp_id, inflight, err
    );

endinterface

// File: rtl/isqrt_pipe_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after ptr, with wrap.
module rr_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_en,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_slot;
    logic            w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_slot  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // ptr < N_REQ and k < N_REQ, so a single subtraction wraps the slot.
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            w_slot = w_sum[ID_W-1:0];
            if (!w_found && i_en && i_req[w_slot]) begin
                o_grant[w_slot] = 1'b1;
                o_idx           = w_slot;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/isqrt_pipe_arbiter.sv
// Shares one no-stall isqrt pipe between N_REQ requesters; requester IDs ride a tag
// shift register alongside the pipe so each result is returned to its originator.
module isqrt_pipe_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int LATENCY = 16,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int CNT_W   = $clog2(LATENCY + 3)
) (
    input logic                 clk,
    input logic                 rst_n,
    isqrt_pipe_arbiter_if.slave bus
);

    logic [ID_W-1:0]  r_ptr;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_gidx;
    logic             w_xfer;
    logic [31:0]      w_sel_x;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .i_req   (bus.req_vld),
        .i_en    (bus.en),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    assign w_xfer      = |w_grant;
    assign bus.req_rdy = w_grant;

    always_comb begin
        w_sel_x = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant[k]) w_sel_x = bus.req_x[32*k +: 32];
        end
    end

    logic            r_pipe_vld;
    logic [31:0]     r_pipe_x;
    logic [ID_W-1:0] r_issue_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_pipe_vld <= 1'b0;
            r_pipe_x   <= '0;
            r_issue_id <= '0;
        end else begin
            r_pipe_vld <= w_xfer;
            if (w_xfer) begin
                r_pipe_x   <= w_sel_x;
                r_issue_id <= w_gidx;
                r_ptr      <= (w_gidx == ID_W'(N_REQ - 1)) ? '0 : w_gidx + ID_W'(1);
            end
        end
    end

    // Stage k holds the tag of the op issued k+1 cycles ago; the last stage meets pipe_res_vld.
    tag_t r_tag [LATENCY];
    tag_t w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LATENCY; k++) r_tag[k] <= '0;
        end else begin
            r_tag[0] <= {r_pipe_vld, TAG_ID_W'(r_issue_id)};
            for (int k = 1; k < LATENCY; k++) r_tag[k] <= r_tag[k-1];
        end
    end

    assign w_head = r_tag[LATENCY-1];

    logic             w_rsp_fire;
    logic             w_tag_bad;
    logic [N_REQ-1:0] w_head_oh;

    assign w_rsp_fire = bus.pipe_res_vld & w_head.vld;
    assign w_head_oh  = N_REQ'(1) << w_head.id;
    // A valid tag naming a nonexistent requester is treated like a misaligned valid.
    assign w_tag_bad  = (bus.pipe_res_vld != w_head.vld) ||
                        (w_head.vld && ({1'b0, w_head.id} >= (TAG_ID_W+1)'(N_REQ)));

    logic [N_REQ-1:0] r_rsp_vld;
    logic [15:0]      r_rsp_y;
    logic [ID_W-1:0]  r_rsp_id;
    logic [CNT_W-1:0] r_inflight;
    logic             r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_vld  <= '0;
            r_rsp_y    <= '0;
            r_rsp_id   <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rsp_vld <= w_rsp_fire ? w_head_oh : '0;
            if (w_rsp_fire) begin
                r_rsp_y  <= bus.pipe_res_y;
                r_rsp_id <= w_head.id[ID_W-1:0];
            end
            if (w_tag_bad) r_err <= 1'b1;
            case ({w_xfer, |r_rsp_vld})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bus.pipe_vld = r_pipe_vld;
    assign bus.pipe_x   = r_pipe_x;
    assign bus.rsp_vld  = r_rsp_vld;
    assign bus.rsp_y    = r_rsp_y;
    assign bus.rsp_id   = r_rsp_id;
    assign bus.inflight = r_inflight;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_isqrt_pipe_arbiter.sv
// Directed bench for isqrt_pipe_arbiter with a behavioural LATENCY-deep sqrt pipe model.
module tb_isqrt_pipe_arbiter;
    import isqrt_arb_pkg::*;

    localparam int N_REQ   = 4;
    localparam int LATENCY = 16;
    localparam int ID_W    = 2;
    localparam int W       = ID_W + 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic late  = 1'b0;

    isqrt_pipe_arbiter_if #(.N_REQ(N_REQ), .LATENCY(LATENCY)) bus ();

    isqrt_pipe_arbiter #(.N_REQ(N_REQ), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- sqrt pipe model ----------------
    function automatic logic [15:0] isqrt32(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'(1) << b);
            if (64'(t) * 64'(t) <= 64'(x)) r = t;
        end
        return r;
    endfunction

    logic        pm_vld [0:LATENCY];
    logic [15:0] pm_y   [0:LATENCY];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LATENCY; k++) begin
                pm_vld[k] <= 1'b0;
                pm_y[k]   <= '0;
            end
        end else begin
            pm_vld[0] <= bus.pipe_vld;
            pm_y[0]   <= isqrt32(bus.pipe_x);
            for (int k = 1; k <= LATENCY; k++) begin
                pm_vld[k] <= pm_vld[k-1];
                pm_y[k]   <= pm_y[k-1];
            end
        end
    end

    assign bus.pipe_res_vld = late ? pm_vld[LATENCY] : pm_vld[LATENCY-1];
    assign bus.pipe_res_y   = late ? pm_y[LATENCY]   : pm_y[LATENCY-1];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int rsp_cnt  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic push_exp(input int id, input int y);
        exp_q.push_back({ID_W'(id), 16'(y)});
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n) begin
            if (bus.inflight > RSP_LAT) check_eq("inflight_max", bus.inflight, RSP_LAT);
            if (bus.rsp_vld != '0) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", bus.rsp_vld, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_vld", bus.rsp_vld, 64'(1) << e[W-1:16]);
                    check_eq("rsp_id",  bus.rsp_id,  e[W-1:16]);
                    check_eq("rsp_y",   bus.rsp_y,   e[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int i, input logic [31:0] v);
        bus.req_x[32*i +: 32] = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((bus.inflight != 0 || exp_q.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        check_eq(tag, bus.inflight, 0);
        check_eq("drain_queue", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int r0;
        logic [31:0] fx [4];
        int          fy [4];
        fx = '{32'd5, 32'd10, 32'd17, 32'd26};
        fy = '{2, 3, 4, 5};

        bus.en      = 1'b0;
        bus.req_vld = '0;
        bus.req_x   = '0;

        // Reset state, asserted between edges
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_pipe_vld", bus.pipe_vld, 0);
        check_eq("rst_pipe_x",   bus.pipe_x,   0);
        check_eq("rst_rsp_vld",  bus.rsp_vld,  0);
        check_eq("rst_rsp_y",    bus.rsp_y,    0);
        check_eq("rst_rsp_id",   bus.rsp_id,   0);
        check_eq("rst_inflight", bus.inflight, 0);
        check_eq("rst_err",      bus.err,      0);
        check_eq("rst_req_rdy",  bus.req_rdy,  0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single op: req 2, x=144 -> 12 after LATENCY+2 cycles
        tick();
        bus.en = 1'b1;
        set_x(2, 32'd144);
        bus.req_vld = 4'b0100;
        #1 check_eq("t1_rdy", bus.req_rdy, 4'b0100);
        push_exp(2, 12);
        tick();
        bus.req_vld = '0;
        lat = 1;
        check_eq("t1_pipe_vld", bus.pipe_vld, 1);
        check_eq("t1_pipe_x",   bus.pipe_x,   144);
        check_eq("t1_inflight", bus.inflight, 1);
        while (bus.rsp_vld == '0 && lat < 40) begin
            tick();
            lat++;
        end
        check_eq("t1_latency", lat, 18);
        check_eq("t1_rsp_vld", bus.rsp_vld, 4'b0100);
        check_eq("t1_pipe_x_hold", bus.pipe_x, 144);
        tick();
        check_eq("t1_inflight_zero", bus.inflight, 0);

        // Fairness: all four valid for 8 cycles from ptr=0
        do_reset();
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) set_x(i, fx[i]);
        bus.req_vld = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 check_eq("t2_rdy", bus.req_rdy, 64'(1) << (k % 4));
            push_exp(k % 4, fy[k % 4]);
            tick();
        end
        bus.req_vld = '0;
        drain("t2_drain");

        // Pointer wrap: ptr=3, only req 1 -> grant 1; then reqs 0,3 from ptr=2
        set_x(2, 32'd400);
        bus.req_vld = 4'b0100;
        #1 check_eq("t3_rdy_2", bus.req_rdy, 4'b0100);
        push_exp(2, 20);
        tick();
        set_x(1, 32'd65535);
        bus.req_vld = 4'b0010;
        #1 check_eq("t3_rdy_1", bus.req_rdy, 4'b0010);
        push_exp(1, 255);
        tick();
        set_x(0, 32'd1000000);
        set_x(3, 32'hFFFF_FFFF);
        bus.req_vld = 4'b1001;
        #1 check_eq("t3_rdy_3", bus.req_rdy, 4'b1000);
        push_exp(3, 65535);
        tick();
        #1 check_eq("t3_rdy_0", bus.req_rdy, 4'b0001);
        push_exp(0, 1000);
        tick();
        bus.req_vld = '0;
        drain("t3_drain");

        // en=0 with all valid: two ops in flight still complete
        set_x(0, 32'd0);
        set_x(1, 32'd17);
        set_x(2, 32'd99);
        set_x(3, 32'd100);
        bus.req_vld = 4'b1111;
        #1 check_eq("t4_rdy_1", bus.req_rdy, 4'b0010);
        push_exp(1, 4);
        tick();
        #1 check_eq("t4_rdy_2", bus.req_rdy, 4'b0100);
        push_exp(2, 9);
        tick();
        bus.en = 1'b0;
        check_eq("t4_inflight_2", bus.inflight, 2);
        for (int k = 0; k < 18; k++) begin
            #1 check_eq("t4_rdy_blocked", bus.req_rdy, 0);
            tick();
            check_eq("t4_no_pipe_vld", bus.pipe_vld, 0);
            if (k == 16) check_eq("t4_inflight_1", bus.inflight, 1);
        end
        check_eq("t4_inflight_0", bus.inflight, 0);
        check_eq("t4_queue", exp_q.size(), 0);
        bus.req_vld = '0;

        // Mismatch: result valid arrives one cycle late
        do_reset();
        late   = 1'b1;
        bus.en = 1'b1;
        set_x(0, 32'd49);
        bus.req_vld = 4'b0001;
        #1 check_eq("t5_rdy", bus.req_rdy, 4'b0001);
        r0 = rsp_cnt;
        tick();
        bus.req_vld = '0;
        lat = 1;
        while (!bus.err && lat < 40) begin
            tick();
            lat++;
        end
        check_eq("t5_err_cycle", lat, 18);
        repeat (5) tick();
        check_eq("t5_err_sticky", bus.err, 1);
        check_eq("t5_no_rsp", rsp_cnt - r0, 0);
        check_eq("t5_inflight", bus.inflight, 1);
        #2 rst_n = 1'b0;
        #1 check_eq("t5_err_cleared", bus.err, 0);
        late = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Async reset with 5 ops in flight
        tick();
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) set_x(i, fx[i]);
        bus.req_vld = 4'b1111;
        repeat (5) tick();
        bus.req_vld = '0;
        check_eq("t6_inflight_5", bus.inflight, 5);
        check_eq("t6_pipe_vld_pre", bus.pipe_vld, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_pipe_vld", bus.pipe_vld, 0);
        check_eq("t6_pipe_x",   bus.pipe_x,   0);
        check_eq("t6_rsp_vld",  bus.rsp_vld,  0);
        check_eq("t6_rsp_y",    bus.rsp_y,    0);
        check_eq("t6_rsp_id",   bus.rsp_id,   0);
        check_eq("t6_inflight", bus.inflight, 0);
        check_eq("t6_err",      bus.err,      0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        r0 = rsp_cnt;
        repeat (25) tick();
        check_eq("t6_no_rsp_after", rsp_cnt - r0, 0);
        check_eq("t6_inflight_after", bus.inflight, 0);
        check_eq("t6_err_after", bus.err, 0);

        check_eq("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
